// File: rtl/pc_gen_if.sv
// Fetch-side request/response bundle for pc_gen: redirect and control
// requests in, registered fetch PC and status out.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall_i;
  logic            br_valid_i;
  logic [XLEN-1:0] br_target_i;
  logic            trap_valid_i;
  logic [XLEN-1:0] trap_target_i;
  logic            halt_req_i;
  logic            resume_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_plus_o;
  logic            pc_valid_o;
  logic            halted_o;
  logic            misalign_o;
  logic [XLEN-1:0] misalign_addr_o;

  modport master (
    output stall_i, br_valid_i, br_target_i, trap_valid_i, trap_target_i,
           halt_req_i, resume_i,
    input  pc_o, pc_plus_o, pc_valid_o, halted_o, misalign_o, misalign_addr_o
  );

  modport slave (
    input  stall_i, br_valid_i, br_target_i, trap_valid_i, trap_target_i,
           halt_req_i, resume_i,
    output pc_o, pc_plus_o, pc_valid_o, halted_o, misalign_o, misalign_addr_o
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: BOOT/RUN/HALT sequencing with
// prioritised redirects (trap > branch > halt > stall > increment).
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter int unsigned     BOOT_CYCLES  = 2
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);
  localparam int unsigned ALIGN_BITS = (INSTR_BYTES == 2) ? 1 : 2;
  localparam int unsigned CNT_W      = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic            trap_ok, br_ok;

  assign trap_ok = (bus.trap_target_i[ALIGN_BITS-1:0] == '0);
  assign br_ok   = (bus.br_target_i[ALIGN_BITS-1:0] == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    mis_d    = 1'b0;
    maddr_d  = maddr_q;
    unique case (state_q)
      S_BOOT: begin
        if (cnt_q == CNT_W'(BOOT_CYCLES - 1)) begin
          state_d = S_RUN;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        // A misaligned trap still claims the cycle, so the branch is not consulted.
        if (bus.trap_valid_i) begin
          if (trap_ok) begin
            pc_d = bus.trap_target_i;
          end else begin
            mis_d   = 1'b1;
            maddr_d = bus.trap_target_i;
          end
        end else if (bus.br_valid_i) begin
          if (br_ok) begin
            pc_d = bus.br_target_i;
          end else begin
            mis_d   = 1'b1;
            maddr_d = bus.br_target_i;
          end
        end else if (bus.halt_req_i) begin
          state_d  = S_HALT;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else if (!bus.stall_i) begin
          pc_d = pc_q + XLEN'(INSTR_BYTES);
        end
      end
      S_HALT: begin
        if (bus.trap_valid_i) begin
          if (trap_ok) begin
            pc_d     = bus.trap_target_i;
            state_d  = S_RUN;
            valid_d  = 1'b1;
            halted_d = 1'b0;
          end else begin
            mis_d   = 1'b1;
            maddr_d = bus.trap_target_i;
          end
        end else if (bus.resume_i) begin
          state_d  = S_RUN;
          valid_d  = 1'b1;
          halted_d = 1'b0;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_BOOT;
      cnt_q    <= '0;
      pc_q     <= RESET_VECTOR;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
      maddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
      maddr_q  <= maddr_d;
    end
  end

  assign bus.pc_o            = pc_q;
  assign bus.pc_plus_o       = pc_q + XLEN'(INSTR_BYTES);
  assign bus.pc_valid_o      = valid_q;
  assign bus.halted_o        = halted_q;
  assign bus.misalign_o      = mis_q;
  assign bus.misalign_addr_o = maddr_q;
endmodule
